sram_mem_stage: RTL
===================

Name: sram_mem_stage

Overview:
- Memory-stage data-memory access unit for the 5-stage ARM pipeline. Sits between the EXE/MEM boundary and the MEM-stage pipeline register.
- Services 32-bit word loads and stores from the pipeline against an external 16-bit-wide SRAM, using two half-word accesses with programmable wait states.
- Drives `ready`. The hazard/freeze logic uses `~ready` to stall all upstream pipeline registers and to hold the MEM register until the access completes.

Parameters:
- ACCESS_CYCLES, 2, cycles each half-word SRAM phase is held (legal range 1..15).
- BASE_ADDR, 1024, CPU byte address that maps to SRAM word 0.
- SRAM_AW, 18, SRAM address width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge).
- rd_en  in  1  load request (MEM_R_en from the EXE/MEM boundary).
- wr_en  in  1  store request (MEM_W_en).
- address  in  32  CPU byte address (ALU result).
- write_data  in  32  store data (Val_Rm).
- read_data  out  32  loaded word; valid while ready==1 after a load.
- ready  out  1  0 while an access is in progress.
- sram_addr  out  SRAM_AW  SRAM half-word address.
- sram_dq_o  out  16  write data to the SRAM pad.
- sram_dq_oe  out  1  pad output enable (top level builds the tristate).
- sram_dq_i  in  16  read data from the SRAM pad.
- sram_we_n  out  1  active-low write strobe.
- sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n  out  1 each  tied 0 (chip, output and byte lanes always enabled).

Behaviour:
- Reset (rst==0 at a clock edge):
  - state=IDLE, counter=0, read_data=0.
  - sram_addr=0, sram_dq_o=0, sram_dq_oe=0, sram_we_n=1.
  - ready=1 combinationally while in IDLE with no request.
  - Reset during any phase aborts the access: the next cycle is IDLE, we_n=1 and oe=0, no DONE pulse, read_data=0.
- Address mapping:
  - word = (address - BASE_ADDR) >> 2, using 32-bit modular subtraction and truncation.
  - Low half goes to sram_addr = {word[SRAM_AW-2:0], 1'b0}; high half goes to {word[SRAM_AW-2:0], 1'b1}.
  - address[1:0] is ignored. Addresses below BASE_ADDR wrap silently with no error.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if wr_en or rd_en, latch the op type (write wins if both are set), word, and write_data; go to LOW with counter=0. Otherwise stay in IDLE.
  - LOW: drive the low-half address.
    - Write: dq_o=wdata[15:0], oe=1, we_n=0.
    - Read: oe=0, we_n=1.
    - The counter increments each cycle. When counter==ACCESS_CYCLES-1: on a read, capture sram_dq_i into read_data[15:0]; then go to HIGH with counter=0.
  - HIGH: same as LOW for the high half, using wdata[31:16] and read_data[31:16]; then go to DONE.
  - DONE: we_n=1, oe=0, ready=1 for exactly one cycle; go to IDLE.
  - All SRAM control outputs are registered. we_n is de-asserted in DONE and in IDLE.
- ready logic:
  - ready = (IDLE && !rd_en && !wr_en) || DONE. This is combinational on the request inputs in IDLE only.
  - Latency: request first seen in cycle 0 gives ready=1 in cycle 2*ACCESS_CYCLES+1.
  - The pipeline advances at the end of the DONE cycle. Any request present in the following IDLE cycle is treated as new.
  - Inputs are don't-care outside IDLE.
- read_data is held after DONE until the next read completes or reset. A write does not modify read_data.

Decomposition:
- Shared package `arm_pkg`:
  - mem_state_t enum {IDLE, LOW, HIGH, DONE}.
  - BASE_ADDR default constant.
  - SRAM_AW constant.
- Single module. No sub-module is required.
- The bench provides a behavioural SRAM model (sram_model) with fixed read data, used for verification only.

Test Plan:
- Reset: hold rst=0 for 2 clocks with rd_en=1 -> ready=1 after release, sram_we_n=1, sram_dq_oe=0, read_data=0x00000000.
- Store: wr_en=1, address=1024, write_data=0xDEADBEEF, ACCESS_CYCLES=2.
  - Cycles 1-2: sram_addr=0, dq_o=0xBEEF, we_n=0.
  - Cycles 3-4: sram_addr=1, dq_o=0xDEAD, we_n=0.
  - Cycle 5: ready=1 and we_n=1. ready is 0 in cycles 0-4.
- Load: model holds half-words 0x5678 at addr 2 and 0x1234 at addr 3; rd_en=1, address=1028 -> read_data=0x12345678 and ready=1 in cycle 5; we_n stays 1 throughout.
- Back-to-back and priority:
  - Store 0xCAFEF00D at 2048, then immediately load 2048 -> load returns 0xCAFEF00D; ready pulses exactly one cycle per access.
  - rd_en=wr_en=1 -> a write is performed.
- Reset mid-access: assert rst=0 during the HIGH phase of a store -> next cycle is IDLE with we_n=1 and oe=0, no ready pulse from DONE, read_data=0.
- Parameter sweep: ACCESS_CYCLES=1 and 4 -> ready rises in cycle 3 and cycle 9 respectively. Address 0 wraps to sram_addr {word[16:0], 0} with word = 0x3FFFFF00 truncated; no hang.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared types and default constants for the ARM pipeline memory stage.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } mem_state_t;

  localparam int unsigned DEFAULT_BASE_ADDR     = 1024;
  localparam int unsigned DEFAULT_SRAM_AW       = 18;
  localparam int unsigned DEFAULT_ACCESS_CYCLES = 2;

endpackage

// File: rtl/sram_mem_stage.sv
// MEM-stage data-memory unit: one 32-bit load/store becomes two 16-bit SRAM
// phases with programmable wait states; ready low stalls the pipeline meanwhile.
module sram_mem_stage
  import arm_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES,
  parameter int unsigned BASE_ADDR     = DEFAULT_BASE_ADDR,
  parameter int unsigned SRAM_AW       = DEFAULT_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_we_n,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  localparam logic [3:0] LAST_COUNT = 4'(ACCESS_CYCLES - 1);

  mem_state_t         state, state_nxt;
  logic [3:0]         counter, counter_nxt;
  logic               is_write, is_write_nxt;
  logic [SRAM_AW-2:0] word, word_nxt;
  logic [31:0]        wdata, wdata_nxt;
  logic [31:0]        read_data_nxt;
  logic [SRAM_AW-1:0] sram_addr_nxt;
  logic [15:0]        dq_o_nxt;
  logic               dq_oe_nxt, we_n_nxt;
  logic [SRAM_AW-2:0] req_word;
  logic               request, phase_end;

  // Modular subtraction: addresses below BASE_ADDR alias high in the SRAM.
  assign req_word  = (SRAM_AW-1)'((address - BASE_ADDR) >> 2);
  assign request   = rd_en | wr_en;
  assign phase_end = (counter == LAST_COUNT);
  assign ready     = ((state == IDLE) && !request) || (state == DONE);

  assign sram_ce_n = 1'b0;
  assign sram_oe_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

  // Pad controls are computed one cycle ahead so the registered outputs line
  // up with the phase they belong to.
  always_comb begin
    state_nxt     = state;
    counter_nxt   = counter;
    is_write_nxt  = is_write;
    word_nxt      = word;
    wdata_nxt     = wdata;
    read_data_nxt = read_data;
    sram_addr_nxt = sram_addr;
    dq_o_nxt      = sram_dq_o;
    dq_oe_nxt     = sram_dq_oe;
    we_n_nxt      = sram_we_n;

    case (state)
      IDLE: begin
        if (request) begin
          state_nxt     = LOW;
          counter_nxt   = 4'd0;
          is_write_nxt  = wr_en;
          word_nxt      = req_word;
          wdata_nxt     = write_data;
          sram_addr_nxt = {req_word, 1'b0};
          dq_o_nxt      = write_data[15:0];
          dq_oe_nxt     = wr_en;
          we_n_nxt      = !wr_en;
        end
      end
      LOW: begin
        if (phase_end) begin
          state_nxt     = HIGH;
          counter_nxt   = 4'd0;
          sram_addr_nxt = {word, 1'b1};
          dq_o_nxt      = wdata[31:16];
          if (!is_write) read_data_nxt[15:0] = sram_dq_i;
        end else begin
          counter_nxt = counter + 4'd1;
        end
      end
      HIGH: begin
        if (phase_end) begin
          state_nxt   = DONE;
          counter_nxt = 4'd0;
          dq_oe_nxt   = 1'b0;
          we_n_nxt    = 1'b1;
          if (!is_write) read_data_nxt[31:16] = sram_dq_i;
        end else begin
          counter_nxt = counter + 4'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      counter    <= 4'd0;
      is_write   <= 1'b0;
      word       <= '0;
      wdata      <= 32'd0;
      read_data  <= 32'd0;
      sram_addr  <= '0;
      sram_dq_o  <= 16'd0;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
    end else begin
      state      <= state_nxt;
      counter    <= counter_nxt;
      is_write   <= is_write_nxt;
      word       <= word_nxt;
      wdata      <= wdata_nxt;
      read_data  <= read_data_nxt;
      sram_addr  <= sram_addr_nxt;
      sram_dq_o  <= dq_o_nxt;
      sram_dq_oe <= dq_oe_nxt;
      sram_we_n  <= we_n_nxt;
    end
  end

endmodule
